// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : timer_pkg
// Brief    : Shared field widths, moduli, state/select encodings and the
//            packed time-word helpers for the board timer controller.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam int c_MS_W    = 10;
    localparam int c_SEC_W   = 6;
    localparam int c_MIN_W   = 6;
    localparam int c_HR_W    = 5;
    localparam int c_TIME_W  = c_HR_W + c_MIN_W + c_SEC_W + c_MS_W;

    localparam int c_MS_MOD  = 1000;
    localparam int c_SEC_MOD = 60;
    localparam int c_MIN_MOD = 60;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_MS  = 2'd0,
        SEL_SEC = 2'd1,
        SEL_MIN = 2'd2,
        SEL_HR  = 2'd3
    } field_sel_t;

    // Member order matches the display word {hr, min, sec, ms}
    typedef struct packed {
        logic [c_HR_W-1:0]  hr;
        logic [c_MIN_W-1:0] min;
        logic [c_SEC_W-1:0] sec;
        logic [c_MS_W-1:0]  ms;
    } time_t;

    function automatic logic [c_TIME_W-1:0] pack_time(input time_t t);
        return t;
    endfunction

    function automatic time_t unpack_time(input logic [c_TIME_W-1:0] w);
        return time_t'(w);
    endfunction

    // sw = {hr, min, sec, ms}; valid only when exactly one bit is set
    function automatic logic sel_valid(input logic [3:0] sw);
        return (sw != 4'd0) && ((sw & (sw - 4'd1)) == 4'd0);
    endfunction

    function automatic field_sel_t sel_field(input logic [3:0] sw);
        if (sw[3])      return SEL_HR;
        else if (sw[2]) return SEL_MIN;
        else if (sw[1]) return SEL_SEC;
        else            return SEL_MS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_pulse.sv
`default_nettype none
// ============================================================================
// Module   : btn_pulse
// Brief    : Counter-based button debouncer followed by a registered
//            rising-edge detector producing a one-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_pulse #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse
);
    localparam int c_CW = $clog2(DB_CYCLES + 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_level;
    logic            r_prev;
    logic            r_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= r_level;
            r_pulse <= r_level & ~r_prev;
            // Count only while raw disagrees with the debounced level; any bounce back restarts
            if (btn_raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CW'(DB_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= btn_raw;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    assign pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/timer_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : timer_ctrl_param
// Brief    : Single-channel countdown/stopwatch controller with debounced
//            buttons, per-field editing and a packed 27-bit time output.
// Revision : 1.0 - initial release
// ============================================================================
module timer_ctrl_param
    import timer_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int DB_CYCLES = 1000000,
    parameter int BIG_STEP  = 10,
    parameter int HR_MAX    = 23
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                toggle,
    input  logic                add_one,
    input  logic                add_ten,
    input  logic                ms_sw,
    input  logic                s_sw,
    input  logic                min_sw,
    input  logic                hr_sw,
    input  logic                mode,
    output logic [c_TIME_W-1:0] out_time,
    output logic                running,
    output logic                done
);
    localparam int    c_PW  = $clog2(TICK_DIV + 1);
    localparam time_t c_MAX = time_t'({5'(HR_MAX), 6'(c_MIN_MOD - 1),
                                       6'(c_SEC_MOD - 1), 10'(c_MS_MOD - 1)});

    logic [2:0]      w_raw, w_pulse;
    logic            w_p_toggle, w_p_one, w_p_ten;
    state_t          r_state;
    time_t           r_time, w_dn, w_up, w_step_time, w_edit_time;
    logic [c_PW-1:0] r_presc;
    logic            r_mode, r_running, r_done;
    logic [3:0]      w_sw;
    field_sel_t      w_sel;
    logic            w_sel_ok, w_edit, w_tick, w_is_zero, w_at_term, w_step_done;
    logic [10:0]     w_step, w_ms_sum, w_ms_wr;
    logic [6:0]      w_sec_sum, w_sec_wr, w_min_sum, w_min_wr;
    logic [5:0]      w_hr_sum, w_hr_wr;
    logic            w_unused;

    assign w_raw = {add_ten, add_one, toggle};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_btn (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(w_raw[gi]),
            .pulse  (w_pulse[gi])
        );
    end

    assign w_p_toggle = w_pulse[0];
    assign w_p_one    = w_pulse[1];
    assign w_p_ten    = w_pulse[2];

    assign w_sw     = {hr_sw, min_sw, s_sw, ms_sw};
    assign w_sel_ok = sel_valid(w_sw);
    assign w_sel    = sel_field(w_sw);
    assign w_edit   = (w_p_one | w_p_ten) & w_sel_ok;
    assign w_step   = w_p_ten ? 11'(BIG_STEP) : 11'd1;

    // One spare bit per field keeps field + step from wrapping before the modulo compare
    assign w_ms_sum  = {1'b0, r_time.ms} + w_step;
    assign w_ms_wr   = (w_ms_sum >= 11'(c_MS_MOD)) ? w_ms_sum - 11'(c_MS_MOD) : w_ms_sum;
    assign w_sec_sum = {1'b0, r_time.sec} + w_step[6:0];
    assign w_sec_wr  = (w_sec_sum >= 7'(c_SEC_MOD)) ? w_sec_sum - 7'(c_SEC_MOD) : w_sec_sum;
    assign w_min_sum = {1'b0, r_time.min} + w_step[6:0];
    assign w_min_wr  = (w_min_sum >= 7'(c_MIN_MOD)) ? w_min_sum - 7'(c_MIN_MOD) : w_min_sum;
    assign w_hr_sum  = {1'b0, r_time.hr} + w_step[5:0];
    assign w_hr_wr   = (w_hr_sum >= 6'(HR_MAX + 1)) ? w_hr_sum - 6'(HR_MAX + 1) : w_hr_sum;
    assign w_unused  = ^{w_ms_wr[10], w_sec_wr[6], w_min_wr[6], w_hr_wr[5]};

    always_comb begin
        w_edit_time = r_time;
        case (w_sel)
            SEL_MS:  w_edit_time.ms  = w_ms_wr[9:0];
            SEL_SEC: w_edit_time.sec = w_sec_wr[5:0];
            SEL_MIN: w_edit_time.min = w_min_wr[5:0];
            SEL_HR:  w_edit_time.hr  = w_hr_wr[4:0];
        endcase
    end

    always_comb begin
        w_dn = r_time;
        if (r_time.ms != '0) begin
            w_dn.ms = r_time.ms - 10'd1;
        end else begin
            w_dn.ms = 10'(c_MS_MOD - 1);
            if (r_time.sec != '0) begin
                w_dn.sec = r_time.sec - 6'd1;
            end else begin
                w_dn.sec = 6'(c_SEC_MOD - 1);
                if (r_time.min != '0) begin
                    w_dn.min = r_time.min - 6'd1;
                end else begin
                    w_dn.min = 6'(c_MIN_MOD - 1);
                    w_dn.hr  = r_time.hr - 5'd1;
                end
            end
        end
    end

    always_comb begin
        w_up = r_time;
        if (r_time.ms != 10'(c_MS_MOD - 1)) begin
            w_up.ms = r_time.ms + 10'd1;
        end else begin
            w_up.ms = '0;
            if (r_time.sec != 6'(c_SEC_MOD - 1)) begin
                w_up.sec = r_time.sec + 6'd1;
            end else begin
                w_up.sec = '0;
                if (r_time.min != 6'(c_MIN_MOD - 1)) begin
                    w_up.min = r_time.min + 6'd1;
                end else begin
                    w_up.min = '0;
                    w_up.hr  = r_time.hr + 5'd1;
                end
            end
        end
    end

    // A PAUSE edit can leave the time already at its end point; never step past it
    assign w_is_zero   = (r_time == '0);
    assign w_tick      = (r_presc == c_PW'(TICK_DIV - 1));
    assign w_at_term   = r_mode ? (r_time == c_MAX) : w_is_zero;
    assign w_step_time = w_at_term ? r_time : (r_mode ? w_up : w_dn);
    assign w_step_done = r_mode ? (w_step_time == c_MAX) : (w_step_time == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_time    <= '0;
            r_presc   <= '0;
            r_mode    <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_p_toggle) begin
                        if (mode || !w_is_zero) begin
                            r_mode    <= mode;
                            r_presc   <= '0;
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end else if (w_edit) begin
                        r_time <= w_edit_time;
                    end
                end
                RUN: begin
                    if (w_p_toggle) begin
                        r_state   <= PAUSE;
                        r_running <= 1'b0;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        r_time  <= w_step_time;
                        if (w_step_done) begin
                            r_state   <= DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + c_PW'(1);
                    end
                end
                PAUSE: begin
                    if (w_p_toggle) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end else if (w_edit) begin
                        r_time <= w_edit_time;
                    end
                end
                DONE: begin
                    if (w_p_toggle) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_time = pack_time(r_time);
    assign running  = r_running;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_ctrl_param
// Brief    : Scoreboard bench for timer_ctrl_param with short debounce/tick.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_ctrl_param;

    localparam int c_DB   = 4;
    localparam int c_TD   = 2;
    localparam int c_BIG  = 10;
    localparam int c_HRM  = 23;

    logic        clk = 1'b0;
    logic        reset, toggle, add_one, add_ten;
    logic        ms_sw, s_sw, min_sw, hr_sw, mode;
    logic [26:0] out_time;
    logic        running, done;

    int          checks = 0;
    int          errors = 0;
    logic [26:0] exp_q[$];

    timer_ctrl_param #(
        .TICK_DIV (c_TD),
        .DB_CYCLES(c_DB),
        .BIG_STEP (c_BIG),
        .HR_MAX   (c_HRM)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .toggle  (toggle),
        .add_one (add_one),
        .add_ten (add_ten),
        .ms_sw   (ms_sw),
        .s_sw    (s_sw),
        .min_sw  (min_sw),
        .hr_sw   (hr_sw),
        .mode    (mode),
        .out_time(out_time),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] mk(input int h, input int m, input int s, input int ms);
        return {5'(h), 6'(m), 6'(s), 10'(ms)};
    endfunction

    function automatic logic [26:0] from_ms(input int t);
        return mk(t / 3600000, (t / 60000) % 60, (t / 1000) % 60, t % 1000);
    endfunction

    task automatic set_sw(input logic m0, input logic s0, input logic mi0, input logic h0);
        ms_sw = m0; s_sw = s0; min_sw = mi0; hr_sw = h0;
    endtask

    task automatic press(input logic t, input logic o, input logic n);
        toggle = t; add_one = o; add_ten = n;
        repeat (c_DB + 2) @(posedge clk);
        #1;
        toggle = 1'b0; add_one = 1'b0; add_ten = 1'b0;
        repeat (c_DB + 4) @(posedge clk);
        #1;
    endtask

    // which: 0 ms, 1 sec, 2 min, 3 hr
    task automatic set_field(input int which, input int val);
        set_sw(which == 0, which == 1, which == 2, which == 3);
        repeat (val / c_BIG) press(1'b0, 1'b0, 1'b1);
        repeat (val % c_BIG) press(1'b0, 1'b1, 1'b0);
        set_sw(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        toggle = 1'b0; add_one = 1'b0; add_ten = 1'b0; mode = 1'b0;
        set_sw(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_change(input logic [26:0] prev, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (out_time !== prev) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        toggle = 1'b0; add_one = 1'b0; add_ten = 1'b0; mode = 1'b0;
        set_sw(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_time !== 27'd0) begin errors++; $display("FAIL reset_time: got %h expected 0", out_time); end
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        reset = 1'b0;
    endtask

    task automatic test_edit();
        int sec, hr;
        logic [26:0] exp;
        do_reset();
        sec = 0; hr = 0;
        set_sw(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            sec = (sec + c_BIG) % 60;
            exp_q.push_back(mk(0, 0, sec, 0));
            press(1'b0, 1'b0, 1'b1);
            exp = exp_q.pop_front();
            checks++;
            if (out_time !== exp) begin errors++; $display("FAIL edit_sec_%0d: got %h expected %h", i, out_time, exp); end
        end
        set_sw(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 25; i++) begin
            hr = (hr + 1) % (c_HRM + 1);
            exp_q.push_back(mk(hr, 0, sec, 0));
            press(1'b0, 1'b1, 1'b0);
            exp = exp_q.pop_front();
            checks++;
            if (out_time !== exp) begin errors++; $display("FAIL edit_hr_%0d: got %h expected %h", i, out_time, exp); end
        end
        set_sw(1'b0, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(mk(1, 0, 10, 0));
        press(1'b0, 1'b1, 1'b0);
        exp = exp_q.pop_front();
        checks++;
        if (out_time !== exp) begin errors++; $display("FAIL edit_two_sw: got %h expected %h", out_time, exp); end
        set_sw(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_bounce();
        int  lat;
        bit  seen;
        logic [26:0] exp;
        do_reset();
        set_sw(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            add_one = ((c / 2) % 2) == 0;
            @(posedge clk);
            #1;
        end
        checks++;
        if (out_time !== 27'd0) begin errors++; $display("FAIL bounce_quiet: got %h expected 0", out_time); end
        exp_q.push_back(mk(0, 0, 0, 1));
        add_one = 1'b1;
        lat = 0; seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (out_time !== 27'd0) begin seen = 1'b1; lat = i; end
        end
        checks++;
        if (lat != c_DB + 2) begin errors++; $display("FAIL bounce_latency: got %0d expected %0d", lat, c_DB + 2); end
        exp = exp_q.pop_front();
        checks++;
        if (out_time !== exp) begin errors++; $display("FAIL bounce_value: got %h expected %h", out_time, exp); end
        add_one = 1'b0;
        repeat (c_DB + 4) @(posedge clk);
        #1;
        checks++;
        if (out_time !== exp) begin errors++; $display("FAIL bounce_single: got %h expected %h", out_time, exp); end
        set_sw(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_countdown();
        bit ok;
        logic [26:0] prev, exp;
        do_reset();
        set_field(1, 1);
        set_field(0, 2);
        checks++;
        if (out_time !== mk(0, 0, 1, 2)) begin errors++; $display("FAIL cd_preload: got %h expected %h", out_time, mk(0, 0, 1, 2)); end
        for (int t = 1001; t >= 0; t--) exp_q.push_back(from_ms(t));
        mode = 1'b0;
        toggle = 1'b1;
        repeat (c_DB + 2) @(posedge clk);
        #1;
        toggle = 1'b0;
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL cd_running: got %b expected 1", running); end
        prev = out_time;
        while (exp_q.size() > 0) begin
            wait_change(prev, ok);
            if (!ok) begin
                errors++; checks++;
                $display("FAIL cd_timeout: got %h expected %h", out_time, exp_q[0]);
                exp_q.delete();
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if (out_time !== exp) begin errors++; $display("FAIL cd_step: got %h expected %h", out_time, exp); end
                prev = out_time;
            end
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL cd_done: got %b expected 1", done); end
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL cd_done_running: got %b expected 0", running); end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (out_time !== 27'd0 || done !== 1'b1) begin
            errors++; $display("FAIL cd_hold: got %h/%b expected 0/1", out_time, done);
        end
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b0 || running !== 1'b0 || out_time !== 27'd0) begin
            errors++; $display("FAIL cd_ack: got %h/%b/%b expected 0/0/0", out_time, running, done);
        end
    endtask

    task automatic test_countup();
        bit ok;
        logic [26:0] exp, top;
        do_reset();
        top = mk(c_HRM, 59, 59, 999);
        set_field(3, c_HRM);
        set_field(2, 59);
        set_field(1, 59);
        set_field(0, 998);
        checks++;
        if (out_time !== mk(c_HRM, 59, 59, 998)) begin
            errors++; $display("FAIL cu_preload: got %h expected %h", out_time, mk(c_HRM, 59, 59, 998));
        end
        exp_q.push_back(top);
        mode = 1'b1;
        toggle = 1'b1;
        repeat (c_DB + 2) @(posedge clk);
        #1;
        toggle = 1'b0;
        mode = 1'b0;
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL cu_running: got %b expected 1", running); end
        wait_change(mk(c_HRM, 59, 59, 998), ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || out_time !== exp) begin errors++; $display("FAIL cu_step: got %h expected %h", out_time, exp); end
        checks++;
        if (done !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL cu_done: got done %b running %b expected 1 0", done, running);
        end
        repeat (10 * c_TD + 4) @(posedge clk);
        #1;
        checks++;
        if (out_time !== top || done !== 1'b1) begin
            errors++; $display("FAIL cu_hold: got %h/%b expected %h/1", out_time, done, top);
        end
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b0 || out_time !== top) begin
            errors++; $display("FAIL cu_ack: got %h/%b expected %h/0", out_time, done, top);
        end
    endtask

    task automatic test_pause_edit();
        bit ok;
        logic [26:0] prev, exp;
        do_reset();
        set_field(1, 1);
        mode = 1'b0;
        // RUN entered 6 edges after this point, PAUSE 17 edges after; ticks land on edges 8..16
        toggle = 1'b1;
        repeat (c_DB + 2) @(posedge clk);
        #1;
        toggle = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        toggle = 1'b1;
        repeat (c_DB + 2) @(posedge clk);
        #1;
        checks++;
        if (running !== 1'b0 || out_time !== mk(0, 0, 0, 995)) begin
            errors++; $display("FAIL pause_entry: got %h/%b expected %h/0", out_time, running, mk(0, 0, 0, 995));
        end
        toggle = 1'b0;
        repeat (c_DB + 4) @(posedge clk);
        #1;
        set_sw(1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mk(0, 0, 0, 996));
        press(1'b0, 1'b1, 1'b0);
        exp = exp_q.pop_front();
        checks++;
        if (out_time !== exp) begin errors++; $display("FAIL pause_edit: got %h expected %h", out_time, exp); end
        exp_q.push_back(mk(0, 0, 0, 995));
        exp_q.push_back(mk(0, 0, 0, 994));
        toggle = 1'b1; add_one = 1'b1;
        repeat (c_DB + 2) @(posedge clk);
        #1;
        checks++;
        if (running !== 1'b1 || out_time !== mk(0, 0, 0, 996)) begin
            errors++; $display("FAIL toggle_wins: got %h/%b expected %h/1", out_time, running, mk(0, 0, 0, 996));
        end
        toggle = 1'b0; add_one = 1'b0;
        prev = out_time;
        while (exp_q.size() > 0) begin
            wait_change(prev, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || out_time !== exp) begin errors++; $display("FAIL resume_step: got %h expected %h", out_time, exp); end
            prev = out_time;
        end
        set_sw(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        set_field(2, 5);
        set_field(1, 30);
        set_field(0, 500);
        checks++;
        if (out_time !== mk(0, 5, 30, 500)) begin errors++; $display("FAIL rst_preload: got %h expected %h", out_time, mk(0, 5, 30, 500)); end
        mode = 1'b0;
        toggle = 1'b1;
        repeat (c_DB + 2) @(posedge clk);
        #1;
        toggle = 1'b0;
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL rst_run: got %b expected 1", running); end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (out_time !== 27'd0 || running !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_run: got %h/%b/%b expected 0/0/0", out_time, running, done);
        end
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (running !== 1'b0 || out_time !== 27'd0) begin
            errors++; $display("FAIL zero_toggle_ignored: got %h/%b expected 0/0", out_time, running);
        end
    endtask

    initial begin
        test_reset();
        test_edit();
        test_bounce();
        test_countdown();
        test_countup();
        test_pause_edit();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/timer_ctrl_param.md
# timer_ctrl_param

Parametrised single-channel countdown/stopwatch controller for the board timer design. Takes raw push-buttons (start/pause, add-one, add-ten) and four field-select switches, debounces and edge-detects the buttons internally, lets the user edit ms/sec/min/hr fields, then counts down to zero or up to a maximum. It produces the packed 27-bit time word consumed by the display path, plus `running` and `done` status.

## Interface
Parameters:
- `TICK_DIV`, 100000: clk cycles per 1 ms tick (100 MHz clk).
- `DB_CYCLES`, 1000000: consecutive stable cycles before a debounced button level changes.
- `BIG_STEP`, 10: increment applied by `add_ten`.
- `HR_MAX`, 23: maximum hour value (≤ 31).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `toggle`  in  1  raw start/pause/acknowledge button.
- `add_one`  in  1  raw button; adds 1 to the selected field.
- `add_ten`  in  1  raw button; adds `BIG_STEP` to the selected field.
- `ms_sw`, `s_sw`, `min_sw`, `hr_sw`  in  1 each  field select; valid only when exactly one is high.
- `mode`  in  1  0 = countdown, 1 = count-up (stopwatch); sampled only in IDLE.
- `out_time`  out  27  {hr[4:0], min[5:0], sec[5:0], ms[9:0]}.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation
- Each raw button goes through a debounce and rising-edge detector that produces a one-cycle pulse (`p_toggle`, `p_one`, `p_ten`).
- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE; all fields 0; `running` = 0; `done` = 0; prescaler 0; latched mode 0.
- IDLE:
  - Edits allowed.
  - `p_toggle` latches `mode` and goes to RUN.
  - Exception: countdown with time = 0 ignores `p_toggle` and stays in IDLE.
- RUN:
  - Prescaler counts 0..TICK_DIV-1.
  - At terminal count, apply one ms step: decrement with borrow (countdown) or increment with carry (count-up).
  - `p_toggle` → PAUSE. Edits are ignored.
- PAUSE: edits allowed; `p_toggle` → RUN. The prescaler value is held, not cleared.
- DONE:
  - Entered from RUN when a countdown step produces 00:00:00.000, or when count-up reaches HR_MAX:59:59.999. Time holds that value.
  - `p_toggle` → IDLE with time unchanged. Edits are ignored.
- Edit rules:
  - Applies only when exactly one select switch is high; otherwise the pulse is dropped.
  - Field = (field + step) mod M, where M = 1000 (ms), 60 (sec/min), HR_MAX+1 (hr). No carry into the neighbouring field.
  - Arithmetic uses field width + 1 bits before the modulo compare, so no overflow.
- Countdown borrow: ms 0→999 borrows from sec; sec 0→59 borrows from min; min 0→59 borrows from hr.
- Count-up carry: ms 999→0 carries into sec; sec 59→0 into min; min 59→0 into hr.
- Simultaneous pulses:
  - `p_toggle` beats any edit in the same cycle; the edit is dropped.
  - `p_ten` beats `p_one`.
- `mode` changes outside IDLE have no effect until the next IDLE→RUN transition.

## Timing
- Debounce: the debounced level changes on the cycle after the raw input has been stable for `DB_CYCLES` consecutive cycles. Any bounce restarts the count.
- Edge pulse: asserted the cycle after the debounced rise, lasting 1 cycle.
- State/field update: registered on the clock edge where the pulse is high; visible on `out_time` the next cycle.
- Total button-to-output latency: `DB_CYCLES` + 2 cycles.
- First RUN tick: `TICK_DIV` cycles after entering RUN from IDLE, because the prescaler is cleared on IDLE→RUN.
- `done`/`running`: registered, asserted the same cycle the state register changes.
- Reset mid-operation (any state): next cycle all outputs are 0, the state is IDLE, and debouncers are cleared to the released level.

## Structure
- Package `timer_pkg`:
  - field widths (10/6/6/5) and modulus constants;
  - state enum {IDLE, RUN, PAUSE, DONE};
  - field-select encoding and the `out_time` pack/unpack helpers.
- Sub-module `btn_pulse` (parameter `DB_CYCLES`): debounce counter plus rising-edge detector, instantiated three times.
- Top holds the FSM, prescaler, field registers and borrow/carry chain.

## Test plan
Simulation uses DB_CYCLES = 4 and TICK_DIV = 2.
- Edit: `s_sw` = 1, press `add_ten` ×7 → sec = 10 (70 mod 60); `hr_sw` = 1, press `add_one` ×25 → hr = 1; a press with two switches high → no change.
- Bounce: `add_one` toggling every 2 cycles for 20 cycles, then stable high → exactly one increment, `DB_CYCLES` + 2 cycles after the stable edge.
- Countdown: set 00:00:01.002, mode 0, toggle.
  - Required sequence: 1.001, 1.000, 0.999, then down to 0.000.
  - `done` = 1 and `running` = 0 the same cycle 0.000 appears; toggle → IDLE with `done` = 0.
- Count-up saturate: preload HR_MAX:59:59.998, mode 1, run → .999 then DONE; value held for 10 further ticks.
- Pause/edit: run countdown, toggle → PAUSE, `add_one` on ms → ms + 1, toggle → RUN resumes from the edited value; toggle and `add_one` together → toggle wins, no increment.
- Reset mid-RUN at 00:05:30.500 → next cycle `out_time` = 0, `running` = 0, `done` = 0, state IDLE; countdown toggle at zero ignored.
